shiftreg_stream_checker: RTL and testbench

//  Downstream consumer of the 8-bit shift-register delay chain. Tracks every shift strobe, requires
//  the chain's reset contents (zeros) to drain first, then compares each emerging word against a

---
 rtl/shiftreg_pkg.sv | 21 ++
 rtl/shiftreg_lfsr.sv | 27 ++
 rtl/shiftreg_stream_checker.sv | 125 ++++++++++++
 tb/tb_shiftreg_stream_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift-register delay chain: checker FSM states,
// LFSR polynomial and seed, and the LFSR step function used by generator and checker.
package shiftreg_pkg;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] LFSR_TAPS    = 8'hB8;  // bits 7,5,4,3
  localparam logic [WIDTH-1:0] DEFAULT_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fibonacci step: feedback is the XOR of the tapped bits, shifted in at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/shiftreg_lfsr.sv
// LFSR word source; the upstream generator and the checker both instantiate this
// so their sequences cannot drift apart.
module shiftreg_lfsr
  import shiftreg_pkg::*;
#(
  parameter logic [WIDTH-1:0] RST_VAL = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  // load wins over step so a restart always begins from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/shiftreg_stream_checker.sv
// BIST checker at the tail of the shift-register chain: drains the reset zeros,
// then compares each emerging word against a local LFSR and records the result.
module shiftreg_stream_checker
  import shiftreg_pkg::*;
#(
  parameter int               DEPTH     = 20000,
  parameter int               NUM_WORDS = 256,
  parameter int               CNT_W     = 16,
  parameter int               ERR_W     = 8,
  parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  // Strobe protocol: every cycle with shift_en=1 is exactly one chain shift and
  // chain_dout is the pre-shift tail word; there is no backpressure.
  input  logic             shift_en,
  input  logic [WIDTH-1:0] chain_dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] first_err_exp,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(NUM_WORDS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] exp_word;
  logic [ERR_W-1:0] err_nxt;
  logic             start_acc;
  logic             sample;
  logic             mismatch;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The single counter counts fill strobes, then payload indices.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    sample    = 1'b0;
    exp_word  = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = FILL;
          start_acc = 1'b1;
        end
      end
      FILL: begin
        sample = shift_en;
        if (shift_en && cnt == FILL_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        sample   = shift_en;
        exp_word = lfsr_q;
        if (shift_en && cnt == WORD_LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mismatch = sample && (chain_dout != exp_word);

  always_comb begin
    err_nxt = err_count;
    if (start_acc)                        err_nxt = '0;
    else if (mismatch && err_count != '1) err_nxt = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      cnt           <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else begin
      busy      <= (state_nxt == FILL) || (state_nxt == CHECK);
      done      <= (state_nxt == DONE);
      pass      <= (state_nxt == DONE) && (err_nxt == '0);
      err_count <= err_nxt;
      if (start_acc) begin
        cnt           <= '0;
        first_err_idx <= '0;
        first_err_got <= '0;
        first_err_exp <= '0;
      end else if (sample) begin
        cnt <= (state == FILL && cnt == FILL_LAST) ? '0 : cnt + CNT_W'(1);
        // err_count still zero means this is the first mismatch of the run
        if (mismatch && err_count == '0) begin
          first_err_idx <= (state == CHECK) ? cnt : '0;
          first_err_got <= chain_dout;
          first_err_exp <= exp_word;
        end
      end
    end
  end

  shiftreg_lfsr #(
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .step (sample && state == CHECK),
    .seed (SEED),
    .q    (lfsr_q)
  );

endmodule

// File: tb/tb_shiftreg_stream_checker.sv
// Bench for shiftreg_stream_checker: a 4-stage behavioural chain fed by a generator
// LFSR, directed runs, and a monitor that checks status snapshots and run results.
module tb_shiftreg_stream_checker;
  import shiftreg_pkg::*;

  localparam int DEPTH = 4;
  localparam int NW    = 8;
  localparam int CNT_W = 16;
  localparam int ERR_W = 2;
  localparam int NSTR  = DEPTH + NW;
  localparam int SW    = 2 + 3 + ERR_W + CNT_W + 16;
  localparam int ALL_K = 99;
  localparam logic [SW-1:0] M_ALL = '1;
  localparam logic [SW-1:0] M_BD  = {2'b00, 2'b11, {(SW-4){1'b0}}};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             shift_en = 1'b0;
  logic [7:0]       chain_dout;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;
  logic [7:0]       first_err_got, first_err_exp;
  state_t           dbg_state;

  logic       chain_clr = 1'b0;
  logic [7:0] preload_val = 8'h00;
  logic [7:0] dout_mask = 8'h00;
  logic [7:0] gen_q;
  logic [7:0] stage [DEPTH];
  logic       finish_req = 1'b0;

  shiftreg_stream_checker #(
    .DEPTH(DEPTH), .NUM_WORDS(NW), .CNT_W(CNT_W), .ERR_W(ERR_W), .SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .shift_en(shift_en), .chain_dout(chain_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_got(first_err_got),
    .first_err_exp(first_err_exp), .dbg_state(dbg_state)
  );

  shiftreg_lfsr #(.RST_VAL(8'hA5)) u_gen (
    .clk(clk), .rst(rst), .load(chain_clr), .step(shift_en), .seed(8'hA5), .q(gen_q)
  );

  // behavioural delay chain; chain_clr empties it and optionally preloads the tail
  always @(posedge clk) begin
    if (chain_clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= 8'h00;
      stage[DEPTH-1] <= preload_val;
    end else if (shift_en) begin
      stage[0] <= gen_q;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end
  assign chain_dout = stage[DEPTH-1] ^ dout_mask;

  // scoreboard
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] snap_q[$];
  logic [SW-1:0] mask_q[$];
  string         name_q[$];
  int checks = 0;
  int fails  = 0;

  logic [SW-1:0] act;
  assign act = {dbg_state, busy, done, pass, err_count, first_err_idx, first_err_got, first_err_exp};

  function automatic logic [SW-1:0] pack(input state_t st, input logic b, input logic d,
      input logic p, input logic [ERR_W-1:0] e, input logic [CNT_W-1:0] i,
      input logic [7:0] g, input logic [7:0] x);
    return {st, b, d, p, e, i, g, x};
  endfunction

  // monitor
  initial begin
    logic          done_q;
    logic [SW-1:0] e, m;
    string         n;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL run_result: done rose, got %h, no result expected", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL run_result: got %h, expected %h", act, e);
          end
        end
      end
      done_q = done;
      while (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        m = mask_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ((act & m) !== (e & m)) begin
          fails++;
          $display("FAIL %s: got %h, expected %h (mask %h)", n, act & m, e & m, m);
        end
      end
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL results_pending: got %0d outstanding runs, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_snap(input logic [SW-1:0] e, input logic [SW-1:0] m, input string n);
    snap_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(n);
  endtask

  task automatic strobe(input int gap, input logic [7:0] mask, input int s);
    repeat (gap) tick();
    shift_en  = 1'b1;
    dout_mask = mask;
    tick();
    shift_en  = 1'b0;
    dout_mask = 8'h00;
    push_snap(pack(IDLE, s < NSTR, s == NSTR, 1'b0, '0, '0, 8'h00, 8'h00), M_BD,
              $sformatf("status_s%0d", s));
  endtask

  task automatic run(input int nstr, input logic [7:0] preload, input int bad_k,
                     input logic [7:0] bad_mask, input int gapmax, input bit mid_start);
    preload_val = preload;
    chain_clr   = 1'b1;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    chain_clr   = 1'b0;
    for (int s = 1; s <= nstr; s++) begin
      logic [7:0] m;
      m = 8'h00;
      if (s > DEPTH && (bad_k == ALL_K || bad_k == s - DEPTH - 1)) m = bad_mask;
      if (mid_start && s == DEPTH + 3) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      strobe($urandom_range(gapmax, 0), m, s);
    end
    tick();
    tick();
  endtask

  // stimulus
  initial begin
    repeat (3) tick();
    push_snap(pack(IDLE, 0, 0, 0, '0, '0, 8'h00, 8'h00), M_ALL, "reset_state");
    rst = 1'b0;
    tick();

    // test 1: reset in the middle of CHECK
    run(DEPTH + 2, 8'h00, -1, 8'h00, 0, 1'b0);
    rst = 1'b1;
    tick();
    push_snap(pack(IDLE, 0, 0, 0, '0, '0, 8'h00, 8'h00), M_ALL, "rst_mid_check");
    tick();
    rst = 1'b0;
    tick();
    push_snap(pack(IDLE, 0, 0, 0, '0, '0, 8'h00, 8'h00), M_ALL, "rst_released");
    tick();

    // test 2: clean run, then strobes in DONE must leave the result frozen
    exp_q.push_back(pack(DONE, 0, 1, 1, 2'd0, 16'd0, 8'h00, 8'h00));
    run(NSTR, 8'h00, -1, 8'h00, 1, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1, 8'hFF, NSTR);
    push_snap(pack(DONE, 0, 1, 1, 2'd0, 16'd0, 8'h00, 8'h00), M_ALL, "done_frozen");
    tick();

    // test 3: payload word 2 (0x95) arrives as 0x94
    exp_q.push_back(pack(DONE, 0, 1, 0, 2'd1, 16'd2, 8'h94, 8'h95));
    run(NSTR, 8'h00, 2, 8'h01, 0, 1'b0);

    // test 4: stale 0x11 at the chain tail fails the first fill strobe
    exp_q.push_back(pack(DONE, 0, 1, 0, 2'd1, 16'd0, 8'h11, 8'h00));
    run(NSTR, 8'h11, -1, 8'h00, 0, 1'b0);

    // test 5: random gaps and an ignored start during CHECK
    exp_q.push_back(pack(DONE, 0, 1, 1, 2'd0, 16'd0, 8'h00, 8'h00));
    run(NSTR, 8'h00, -1, 8'h00, 5, 1'b1);

    // test 6: every payload word inverted; 2-bit error count saturates at 3
    exp_q.push_back(pack(DONE, 0, 1, 0, 2'd3, 16'd0, 8'h5A, 8'hA5));
    run(NSTR, 8'h00, ALL_K, 8'hFF, 1, 1'b0);

    finish_req = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor_stall: got no summary, expected one");
    $fatal(1);
  end

endmodule
